// File: rtl/debug_send_fsm_pkg.sv
// Shared debug-frame definitions: default field widths, frame sizing helpers,
// host protocol opcodes and the transmit FSM state encoding.
package debug_send_fsm_pkg;

    localparam int DEF_UART_BITS        = 8;
    localparam int DEF_CLK_COUNTER_BITS = 32;
    localparam int DEF_IF_ID_LEN        = 64;
    localparam int DEF_ID_EX_LEN        = 144;
    localparam int DEF_EX_MEM_LEN       = 72;
    localparam int DEF_MEM_WB_LEN       = 71;
    localparam int DEF_RF_REGS_LEN      = 1024;

    // Host-side command bytes; the decoder on the PC uses the same values.
    localparam logic [7:0] OP_STEP = 8'h53;
    localparam logic [7:0] OP_STOP = 8'h51;

    typedef enum logic [1:0] {
        IDLE,
        SEND_BYTE,
        WAIT_TX,
        DONE
    } sendState_e;

    function automatic int frameBits(input int clkBits, input int ifId, input int idEx,
                                     input int exMem, input int memWb, input int rfRegs);
        return clkBits + ifId + idEx + exMem + memWb + rfRegs;
    endfunction

    function automatic int frameBytes(input int bits, input int uartBits);
        return (bits + uartBits - 1) / uartBits;
    endfunction

endpackage

// File: rtl/debug_send_fsm.sv
// Snapshots the pipeline debug state on a start pulse and streams it MSB-first,
// one byte per UART TX handshake, then pulses o_send_done.
module debug_send_fsm
    import debug_send_fsm_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int CLK_COUNTER_BITS = DEF_CLK_COUNTER_BITS,
    parameter int IF_ID_LEN        = DEF_IF_ID_LEN,
    parameter int ID_EX_LEN        = DEF_ID_EX_LEN,
    parameter int EX_MEM_LEN       = DEF_EX_MEM_LEN,
    parameter int MEM_WB_LEN       = DEF_MEM_WB_LEN,
    parameter int RF_REGS_LEN      = DEF_RF_REGS_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_send_start,
    input  logic [CLK_COUNTER_BITS-1:0] i_clk_count,
    input  logic [IF_ID_LEN-1:0]        i_if_id,
    input  logic [ID_EX_LEN-1:0]        i_id_ex,
    input  logic [EX_MEM_LEN-1:0]       i_ex_mem,
    input  logic [MEM_WB_LEN-1:0]       i_mem_wb,
    input  logic [RF_REGS_LEN-1:0]      i_rf_regs,
    input  logic                        i_tx_done,
    output logic                        o_tx_start,
    output logic [UART_BITS-1:0]        o_tx_data,
    output logic                        o_busy,
    output logic                        o_send_done
);

    localparam int FRAME_BITS  = frameBits(CLK_COUNTER_BITS, IF_ID_LEN, ID_EX_LEN,
                                           EX_MEM_LEN, MEM_WB_LEN, RF_REGS_LEN);
    localparam int FRAME_BYTES = frameBytes(FRAME_BITS, UART_BITS);
    localparam int SHIFT_W     = FRAME_BYTES * UART_BITS;
    localparam int CNT_W       = $clog2(FRAME_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    sendState_e         state_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   byteCount_q;
    logic               txStart_q;
    logic               sendDone_q;
    logic               busy_q;

    // Outputs are registered alongside the state so each pulse lines up with
    // the state it belongs to, with no path from inputs to outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            byteCount_q <= '0;
            txStart_q   <= 1'b0;
            sendDone_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            txStart_q  <= 1'b0;
            sendDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_send_start) begin
                        // Zero extension supplies the MSB-side pad up to a whole byte count.
                        shift_q     <= SHIFT_W'({i_clk_count, i_if_id, i_id_ex,
                                                 i_ex_mem, i_mem_wb, i_rf_regs});
                        byteCount_q <= '0;
                        state_q     <= SEND_BYTE;
                        txStart_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                SEND_BYTE: begin
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        shift_q     <= shift_q << UART_BITS;
                        byteCount_q <= byteCount_q + CNT_W'(1);
                        if (byteCount_q == LAST_BYTE) begin
                            state_q    <= DONE;
                            sendDone_q <= 1'b1;
                        end else begin
                            state_q   <= SEND_BYTE;
                            txStart_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_start  = txStart_q;
    assign o_tx_data   = shift_q[SHIFT_W-1 -: UART_BITS];
    assign o_busy      = busy_q;
    assign o_send_done = sendDone_q;

endmodule

// File: tb/tb_debug_send_fsm.sv
// Directed bench for debug_send_fsm with a 52-bit (7-byte) debug frame and a
// simple UART TX model that answers each byte after a configurable delay.
module tb_debug_send_fsm;

    localparam int UB  = 8;
    localparam int CB  = 8;
    localparam int IFL = 8;
    localparam int IDL = 8;
    localparam int EXL = 8;
    localparam int MWL = 4;
    localparam int RFL = 16;
    localparam int NB  = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_send_start = 1'b0;
    logic [CB-1:0]  i_clk_count = '0;
    logic [IFL-1:0] i_if_id = '0;
    logic [IDL-1:0] i_id_ex = '0;
    logic [EXL-1:0] i_ex_mem = '0;
    logic [MWL-1:0] i_mem_wb = '0;
    logic [RFL-1:0] i_rf_regs = '0;
    logic           i_tx_done = 1'b0;
    logic           o_tx_start;
    logic [UB-1:0]  o_tx_data;
    logic           o_busy;
    logic           o_send_done;

    always #5 clk = ~clk;

    debug_send_fsm #(
        .UART_BITS(UB), .CLK_COUNTER_BITS(CB), .IF_ID_LEN(IFL), .ID_EX_LEN(IDL),
        .EX_MEM_LEN(EXL), .MEM_WB_LEN(MWL), .RF_REGS_LEN(RFL)
    ) dut (
        .clk(clk), .rst(rst), .i_send_start(i_send_start), .i_clk_count(i_clk_count),
        .i_if_id(i_if_id), .i_id_ex(i_id_ex), .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb),
        .i_rf_regs(i_rf_regs), .i_tx_done(i_tx_done), .o_tx_start(o_tx_start),
        .o_tx_data(o_tx_data), .o_busy(o_busy), .o_send_done(o_send_done)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] expBytes [NB] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h66, 8'h77};
    logic [7:0] gotBytes [16];
    int startRel [16];
    int nStarts, nDone, nTxDone, doneRel, lastTxDoneRel;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cc, input logic [7:0] ifid, input logic [7:0] idex,
                                 input logic [7:0] exmem, input logic [3:0] memwb, input logic [15:0] rf);
        i_clk_count = cc;
        i_if_id     = ifid;
        i_id_ex     = idex;
        i_ex_mem    = exmem;
        i_mem_wb    = memwb;
        i_rf_regs   = rf;
    endtask

    task automatic startFrame();
        i_send_start = 1'b1;
        tick();
    endtask

    // Called in the cycle right after the accepting edge (rel = 1). Returns in the
    // cycle after o_send_done, or one cycle after a reset injected mid-frame.
    task automatic runFrame(input int delay, input bit noise, input int abortAfter, input int holdCycles);
        int pending = 0;
        int rel = 1;
        bit seenDone = 1'b0;
        nStarts = 0; nDone = 0; nTxDone = 0; doneRel = -1; lastTxDoneRel = -1;
        for (int c = 0; c < 300; c++) begin
            if (abortAfter > 0 && nTxDone == abortAfter) begin
                rst = 1'b1; i_tx_done = 1'b0; i_send_start = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
            if (o_tx_start) begin
                if (nStarts < 16) begin
                    gotBytes[nStarts] = o_tx_data;
                    startRel[nStarts] = rel;
                end
                nStarts++;
            end
            if (o_send_done) begin
                nDone++;
                doneRel = rel;
                seenDone = 1'b1;
            end
            i_tx_done = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    i_tx_done = 1'b1;
                    nTxDone++;
                    lastTxDoneRel = rel;
                    if (nStarts >= 1 && nStarts <= 16)
                        checkOutput("tx_data stable", o_tx_data, gotBytes[nStarts-1]);
                end
            end
            if (o_tx_start) pending = delay;
            i_send_start = (rel <= holdCycles);
            if (noise) begin
                if (o_tx_start) i_tx_done = 1'b1;
                if (pending > 0 && !o_tx_start) i_send_start = 1'b1;
                if (o_send_done) i_send_start = 1'b1;
            end
            tick();
            rel++;
            if (seenDone) begin
                i_send_start = 1'b0;
                i_tx_done = 1'b0;
                return;
            end
        end
        i_send_start = 1'b0;
        i_tx_done = 1'b0;
        checkOutput("frame timeout done count", nDone, 1);
    endtask

    task automatic verifyFrame(input string tag);
        for (int i = 0; i < NB; i++)
            checkOutput($sformatf("%s byte%0d", tag, i), gotBytes[i], expBytes[i]);
        checkOutput({tag, " tx_start count"}, nStarts, NB);
        checkOutput({tag, " done count"}, nDone, 1);
        checkOutput({tag, " done after last tx_done"}, doneRel, lastTxDoneRel + 1);
        checkOutput({tag, " busy low after done"}, o_busy, 0);
        checkOutput({tag, " no tx_start after done"}, o_tx_start, 0);
    endtask

    initial begin
        tick();
        tick();
        checkOutput("reset tx_start", o_tx_start, 0);
        checkOutput("reset send_done", o_send_done, 0);
        checkOutput("reset busy", o_busy, 0);
        checkOutput("reset tx_data", o_tx_data, 0);
        rst = 1'b0;
        tick();

        // Basic frame with a 3-cycle TX.
        applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 4'h5, 16'h6677);
        startFrame();
        checkOutput("basic busy at k+1", o_busy, 1);
        runFrame(3, 1'b0, 0, 0);
        verifyFrame("basic");
        checkOutput("basic first tx_start rel", startRel[0], 1);
        checkOutput("basic second tx_start rel", startRel[1], 5);

        // Inputs change right after acceptance; the frame must not.
        tick();
        startFrame();
        applyStimulus('1, '1, '1, '1, '1, '1);
        runFrame(3, 1'b0, 0, 0);
        verifyFrame("snapshot");
        applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 4'h5, 16'h6677);

        // Stray tx_done in IDLE and SEND_BYTE, stray starts in WAIT_TX and DONE.
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        checkOutput("idle tx_done ignored busy", o_busy, 0);
        checkOutput("idle tx_done ignored start", o_tx_start, 0);
        startFrame();
        runFrame(3, 1'b1, 0, 0);
        verifyFrame("noise");
        begin
            int extra = 0;
            for (int i = 0; i < 6; i++) begin
                if (o_tx_start || o_busy) extra++;
                tick();
            end
            checkOutput("noise no second frame", extra, 0);
        end

        // Reset right after the third tx_done abandons the frame.
        startFrame();
        runFrame(3, 1'b0, 3, 0);
        checkOutput("reset mid busy", o_busy, 0);
        checkOutput("reset mid tx_start", o_tx_start, 0);
        checkOutput("reset mid send_done", o_send_done, 0);
        checkOutput("reset mid tx_data", o_tx_data, 0);
        begin
            int stray = 0;
            for (int i = 0; i < 6; i++) begin
                if (o_send_done || o_tx_start) stray++;
                tick();
            end
            checkOutput("reset mid no stray output", stray, 0);
        end
        startFrame();
        runFrame(3, 1'b0, 0, 0);
        verifyFrame("after reset");

        // Fastest TX: tx_done in the cycle after each tx_start.
        tick();
        startFrame();
        runFrame(1, 1'b0, 0, 0);
        verifyFrame("fast");
        for (int i = 0; i < NB; i++)
            checkOutput($sformatf("fast tx_start rel%0d", i), startRel[i], 1 + 2 * i);
        checkOutput("fast send_done rel", doneRel, 15);

        // Start pulse in the cycle after o_send_done.
        tick();
        startFrame();
        runFrame(3, 1'b0, 0, 0);
        verifyFrame("b2b first");
        startFrame();
        i_send_start = 1'b0;
        checkOutput("b2b tx_start 2 after done", o_tx_start, 1);
        runFrame(3, 1'b0, 0, 0);
        verifyFrame("b2b second");

        // Start held high across several cycles launches a single frame.
        tick();
        startFrame();
        runFrame(3, 1'b0, 0, 4);
        verifyFrame("held start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_send_fsm.md
# debug_send_fsm

Transmit side of the debug unit's step/run protocol. On a one-cycle start pulse from the step controller, it snapshots the pipeline debug state into a byte-aligned frame. The debug state is the clock counter, the four pipeline latches and the flattened register file. It then streams the frame MSB-first, one byte at a time, through the UART transmitter's start/done handshake, and finally pulses `o_send_done` back to the controller. It sits between the step controller and the UART TX instance.

## Interface
Parameters:
- `UART_BITS`, default `` `UART_BITS ``: byte width (8).
- `CLK_COUNTER_BITS`, default `` `CLK_COUNTER_BITS ``: width of the clock-count field.
- `IF_ID_LEN`, `ID_EX_LEN`, `EX_MEM_LEN`, `MEM_WB_LEN`, default the same-named macros: flattened pipeline latch widths.
- `RF_REGS_LEN`, default `` `RF_REGS_LEN ``: flattened register-file width.

Derived local parameters:
- `FRAME_BITS` is the sum of the six field widths above.
- `FRAME_BYTES` = ceil(`FRAME_BITS` / `UART_BITS`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_send_start` in 1: one-cycle frame request.
- `i_clk_count` in `CLK_COUNTER_BITS`: cycles executed.
- `i_if_id`, `i_id_ex`, `i_ex_mem`, `i_mem_wb` in the respective `*_LEN` widths: latch contents.
- `i_rf_regs` in `RF_REGS_LEN`: register file contents.
- `i_tx_done` in 1: UART TX finished the current byte.
- `o_tx_start` out 1: one-cycle byte-send request.
- `o_tx_data` out `UART_BITS`: byte to transmit.
- `o_busy` out 1: a frame is in progress.
- `o_send_done` out 1: one-cycle pulse when the frame is complete.

## Operation
- Frame layout is {pad, `i_clk_count`, `i_if_id`, `i_id_ex`, `i_ex_mem`, `i_mem_wb`, `i_rf_regs`}. The pad is zero bits at the MSB end, bringing the width to `FRAME_BYTES`*`UART_BITS`. Bytes go out MSB-first.
- State machine:
  - IDLE: if `i_send_start`, load the frame into the shift register, clear the byte counter, go to SEND_BYTE.
  - SEND_BYTE: `o_tx_start`=1, go to WAIT_TX.
  - WAIT_TX: on `i_tx_done`, shift the register left by `UART_BITS` and increment the counter. If the counter was `FRAME_BYTES`-1, go to DONE; otherwise go to SEND_BYTE. Without `i_tx_done`, stay in WAIT_TX.
  - DONE: `o_send_done`=1, go to IDLE.
  - Any unencoded state goes to IDLE.
- `o_tx_data` is always the top `UART_BITS` of the shift register. It is stable from SEND_BYTE through the end of WAIT_TX.
- `o_busy` is 1 in every state except IDLE.
- The inputs are sampled only on the accepting edge. Later changes do not affect the frame in flight.
- Byte counter width: clog2(`FRAME_BYTES`)+1. There is no wrap within a frame.

Boundary conditions:
- `i_send_start` outside IDLE, including in DONE, is ignored.
- `i_tx_done` outside WAIT_TX is ignored.
- `rst` mid-frame returns to IDLE with all outputs 0 the next cycle. No `o_send_done` is produced and the partial frame is abandoned.
- `i_send_start` held high for several cycles starts exactly one frame. It starts another only if it is still high in IDLE after DONE.

## Timing
- Reset values:
  - `o_tx_start`=0, `o_send_done`=0, `o_busy`=0.
  - `o_tx_data`=0, because the shift register clears.
  - State IDLE, counter 0.
- Start accepted at edge k: `o_tx_start` is high during cycle k+1 and `o_busy` is high from cycle k+1.
- `i_tx_done` high in WAIT_TX at cycle m:
  - If more bytes remain, the next `o_tx_start` is high in cycle m+1.
  - After the last byte, `o_send_done` is high in cycle m+1 and `o_busy` is low from cycle m+2.
- Minimum frame, when `i_tx_done` arrives in the cycle after each `o_tx_start`: 2*`FRAME_BYTES`+1 cycles from the accepting edge to `o_send_done`.
- All outputs are decoded from registered state and the shift register. There is no combinational input-to-output path.

## Structure
- `FRAME_BITS` and `FRAME_BYTES` derivation macros and the `OP_STEP`/`OP_STOP` opcodes belong in the shared `constants.vh`, so the host-side decoder and this block agree.
- No sub-module. The block is a single FSM plus a `FRAME_BYTES`*`UART_BITS` shift register and a counter. The UART TX is instantiated by the debug-unit top.

## Test plan
Test configuration: CLK_COUNTER_BITS=8, IF_ID_LEN=8, ID_EX_LEN=8, EX_MEM_LEN=8, MEM_WB_LEN=4, RF_REGS_LEN=16. This gives FRAME_BITS=52 and FRAME_BYTES=7. The TX model raises `i_tx_done` 3 cycles after each `o_tx_start` unless stated otherwise.

1. Basic frame. Stimulus: clk_count=0x11, if_id=0x22, id_ex=0x33, ex_mem=0x44, mem_wb=0x5, rf=0x6677, one start pulse. Required: bytes 0x01,0x12,0x23,0x34,0x45,0x66,0x77 in that order, then one `o_send_done` in the cycle after the 7th `i_tx_done`.
2. Snapshot. Stimulus: as in scenario 1, then drive all inputs to all-ones the cycle after start. Required: identical byte sequence to scenario 1.
3. Ignored events. Stimulus: start pulses during WAIT_TX and during DONE; `i_tx_done` pulses in IDLE and SEND_BYTE. Required: exactly one 7-byte frame, no extra `o_tx_start`.
4. Reset mid-frame. Stimulus: assert `rst` after the 3rd `i_tx_done`. Required: the next cycle has `o_busy`=0, `o_tx_start`=0 and no `o_send_done`. A subsequent start sends the full frame beginning with 0x01.
5. Fast TX. Stimulus: `i_tx_done` in the cycle after every `o_tx_start`, start accepted at edge k. Required: `o_tx_start` at cycles k+1, k+3, …, k+13, and `o_send_done` at cycle k+15.
6. Back-to-back. Stimulus: a start pulse in the cycle after `o_send_done`. Required: the second frame's first `o_tx_start` is 2 cycles after `o_send_done`.
